jk_sync_counter: RTL and testbench

- Synchronous modulo-N up/down counter built from per-bit JK toggle cells.
- Sits directly downstream of the JK flip-flop stage:
  - generates each bit's J/K drive from the current Q bus;
  - exports Q and Q_prim buses, as the JK flip-flops do.
- Provides load, enable, terminal-count and wrap indication, for use as a divider/sequencer.

---
 rtl/jk_sync_counter.sv | 116 +++++++++++
 tb/tb_jk_sync_counter.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/jk_sync_counter.sv
// Synchronous modulo-MODULUS up/down counter built from per-bit JK toggle cells.
// Optional build macro JK_CTR_SATURATE_EN: saturate at the limits instead of wrapping.
module jk_sync_counter #(
   parameter int WIDTH   = 4,
   parameter int MODULUS = 10
) (
   input  logic             CLK,
   input  logic             Clear,
   input  logic             En,
   input  logic             Up,
   input  logic             Load,
   input  logic [WIDTH-1:0] D,
   output logic [WIDTH-1:0] Q,
   output logic [WIDTH-1:0] Q_prim,
   output logic             TC,
   output logic             Wrap
);

   localparam logic [WIDTH-1:0] MAX_VAL = WIDTH'(MODULUS - 1);
   localparam logic [WIDTH:0]   MOD_EXT = (WIDTH + 1)'(MODULUS);

   logic [WIDTH-1:0] q_r;
   logic [WIDTH-1:0] q_prim_r;
   logic             wrap_r;
   logic [WIDTH-1:0] t_up;
   logic [WIDTH-1:0] t_dn;
   logic [WIDTH-1:0] j;
   logic [WIDTH-1:0] k;
   logic [WIDTH-1:0] q_next;
   logic [WIDTH-1:0] load_val;
   logic             count_en;
   logic             at_limit;
   logic             wrap_evt;

   // Loads of values outside the count range are forced to zero.
   function automatic logic [WIDTH-1:0] clamp_load(input logic [WIDTH-1:0] d);
      return ({1'b0, d} < MOD_EXT) ? d : '0;
   endfunction

   function automatic logic [WIDTH-1:0] jk_next(input logic [WIDTH-1:0] q,
                                                input logic [WIDTH-1:0] jv,
                                                input logic [WIDTH-1:0] kv);
      return (jv & ~q) | (~kv & q);
   endfunction

   assign load_val = clamp_load(D);
   assign count_en = En & ~Load;
   assign at_limit = Up ? (q_r == MAX_VAL) : (q_r == '0);

   always_comb begin
      t_up = '0;
      t_dn = '0;
      t_up[0] = 1'b1;
      t_dn[0] = 1'b1;
      for (int i = 1; i < WIDTH; i++) begin
         t_up[i] = t_up[i-1] & q_r[i-1];
         t_dn[i] = t_dn[i-1] & q_prim_r[i-1];
      end
   end

   // J/K drive: load forces each cell to D, wrap steers cells to the far limit.
   always_comb begin
      j = '0;
      k = '0;
      if (Load) begin
         j = load_val;
         k = ~load_val;
      end else if (En) begin
         if (at_limit) begin
`ifdef JK_CTR_SATURATE_EN
            j = '0;
            k = '0;
`else
            if (Up) begin
               j = '0;
               k = q_r;
            end else begin
               j = MAX_VAL;
               k = ~MAX_VAL;
            end
`endif
         end else if (Up) begin
            j = t_up;
            k = t_up;
         end else begin
            j = t_dn;
            k = t_dn;
         end
      end
      q_next = jk_next(q_r, j, k);
   end

`ifdef JK_CTR_SATURATE_EN
   assign wrap_evt = 1'b0;
`else
   assign wrap_evt = count_en & at_limit;
`endif

   always_ff @(posedge CLK or posedge Clear) begin
      if (Clear) begin
         q_r      <= '0;
         q_prim_r <= '1;
         wrap_r   <= 1'b0;
      end else begin
         q_r      <= q_next;
         q_prim_r <= ~q_next;
         wrap_r   <= wrap_evt;
      end
   end

   assign Q      = q_r;
   assign Q_prim = q_prim_r;
   assign Wrap   = wrap_r;
   assign TC     = count_en & at_limit;

endmodule

// File: tb/tb_jk_sync_counter.sv
// Self-checking bench for jk_sync_counter (WIDTH=4, MODULUS=10) against an integer reference model.
// Honours JK_CTR_SATURATE_EN in the model when the design is built with it.
module tb_jk_sync_counter;

   localparam int W   = 4;
   localparam int MOD = 10;

   logic         CLK = 1'b0;
   logic         Clear = 1'b1;
   logic         En = 1'b0;
   logic         Up = 1'b1;
   logic         Load = 1'b0;
   logic [W-1:0] D = '0;
   logic [W-1:0] Q;
   logic [W-1:0] Q_prim;
   logic         TC;
   logic         Wrap;

   int checks = 0;
   int errors = 0;

   int   m_q = 0;
   logic m_wrap = 1'b0;
   logic tc_obs;
   logic tc_exp;

   jk_sync_counter #(.WIDTH(W), .MODULUS(MOD)) dut (
      .CLK(CLK), .Clear(Clear), .En(En), .Up(Up), .Load(Load), .D(D),
      .Q(Q), .Q_prim(Q_prim), .TC(TC), .Wrap(Wrap)
   );

   always #5 CLK = ~CLK;

   initial begin
      #1_000_000;
      $display("FAIL watchdog: time limit reached, bench did not finish");
      $fatal(1, "watchdog");
   end

   // Reference model: plain integer arithmetic on the count value.
   task automatic model_edge();
      if (Clear) begin
         m_q = 0;
         m_wrap = 1'b0;
      end else if (Load) begin
         m_q = (int'(D) < MOD) ? int'(D) : 0;
         m_wrap = 1'b0;
      end else if (En) begin
         m_wrap = 1'b0;
         if (Up) begin
            if (m_q == MOD - 1) begin
`ifndef JK_CTR_SATURATE_EN
               m_q = 0;
               m_wrap = 1'b1;
`endif
            end else m_q = m_q + 1;
         end else begin
            if (m_q == 0) begin
`ifndef JK_CTR_SATURATE_EN
               m_q = MOD - 1;
               m_wrap = 1'b1;
`endif
            end else m_q = m_q - 1;
         end
      end else begin
         m_wrap = 1'b0;
      end
   endtask

   // Apply inputs, sample TC before the edge, advance one edge, settle.
   task automatic drive_edge(input logic en, input logic up, input logic ld, input logic [W-1:0] d);
      En = en; Up = up; Load = ld; D = d;
      #1;
      tc_obs = TC;
      tc_exp = en && !ld && ((up && m_q == MOD - 1) || (!up && m_q == 0));
      @(posedge CLK);
      model_edge();
      #1;
   endtask

   task automatic test_reset();
      Clear = 1'b1;
      repeat (2) @(posedge CLK);
      #1;
      checks++; if (Q !== 4'd0)     begin errors++; $display("FAIL reset_q: got %0d want 0", Q); end
      checks++; if (Q_prim !== 4'hF) begin errors++; $display("FAIL reset_qp: got %h want f", Q_prim); end
      checks++; if (Wrap !== 1'b0)  begin errors++; $display("FAIL reset_wrap: got %b want 0", Wrap); end
      Clear = 1'b0;
      m_q = 0; m_wrap = 1'b0;
      repeat (6) drive_edge(1'b1, 1'b1, 1'b0, '0);
      checks++; if (Q !== 4'(m_q)) begin errors++; $display("FAIL reset_pre_q: got %0d want %0d", Q, m_q); end
      #3;
      Clear = 1'b1;
      #1;
      checks++; if (Q !== 4'd0)      begin errors++; $display("FAIL reset_async_q: got %0d want 0", Q); end
      checks++; if (Q_prim !== 4'hF) begin errors++; $display("FAIL reset_async_qp: got %h want f", Q_prim); end
      checks++; if (Wrap !== 1'b0)   begin errors++; $display("FAIL reset_async_wrap: got %b want 0", Wrap); end
      m_q = 0; m_wrap = 1'b0;
      repeat (2) begin
         drive_edge(1'b1, 1'b1, 1'b0, '0);
         checks++; if (Q !== 4'd0) begin errors++; $display("FAIL reset_hold_q: got %0d want 0", Q); end
      end
      Clear = 1'b0;
      // Clear arriving right after a wrap must kill the pending Wrap pulse.
      drive_edge(1'b0, 1'b1, 1'b1, 4'd9);
      drive_edge(1'b1, 1'b1, 1'b0, '0);
      checks++; if (Wrap !== m_wrap) begin errors++; $display("FAIL reset_wrap_pre: got %b want %b", Wrap, m_wrap); end
      Clear = 1'b1;
      #1;
      checks++; if (Wrap !== 1'b0) begin errors++; $display("FAIL reset_wrap_kill: got %b want 0", Wrap); end
      m_q = 0; m_wrap = 1'b0;
      Clear = 1'b0;
   endtask

   task automatic test_up_count();
      for (int i = 0; i < 12; i++) begin
         drive_edge(1'b1, 1'b1, 1'b0, '0);
         checks++; if (tc_obs !== tc_exp) begin errors++; $display("FAIL up_tc[%0d]: got %b want %b", i, tc_obs, tc_exp); end
         checks++; if (Q !== 4'(m_q))     begin errors++; $display("FAIL up_q[%0d]: got %0d want %0d", i, Q, m_q); end
         checks++; if (Q_prim !== ~4'(m_q)) begin errors++; $display("FAIL up_qp[%0d]: got %h want %h", i, Q_prim, ~4'(m_q)); end
         checks++; if (Wrap !== m_wrap)   begin errors++; $display("FAIL up_wrap[%0d]: got %b want %b", i, Wrap, m_wrap); end
      end
   endtask

   task automatic test_down_count();
      drive_edge(1'b0, 1'b0, 1'b1, 4'd2);
      for (int i = 0; i < 4; i++) begin
         drive_edge(1'b1, 1'b0, 1'b0, '0);
         checks++; if (tc_obs !== tc_exp) begin errors++; $display("FAIL dn_tc[%0d]: got %b want %b", i, tc_obs, tc_exp); end
         checks++; if (Q !== 4'(m_q))     begin errors++; $display("FAIL dn_q[%0d]: got %0d want %0d", i, Q, m_q); end
         checks++; if (Q_prim !== ~4'(m_q)) begin errors++; $display("FAIL dn_qp[%0d]: got %h want %h", i, Q_prim, ~4'(m_q)); end
         checks++; if (Wrap !== m_wrap)   begin errors++; $display("FAIL dn_wrap[%0d]: got %b want %b", i, Wrap, m_wrap); end
      end
   endtask

   task automatic test_load();
      drive_edge(1'b1, 1'b1, 1'b1, 4'd7);
      checks++; if (tc_obs !== 1'b0) begin errors++; $display("FAIL load_tc: got %b want 0", tc_obs); end
      checks++; if (Q !== 4'd7)      begin errors++; $display("FAIL load_q7: got %0d want 7", Q); end
      drive_edge(1'b0, 1'b0, 1'b1, 4'd12);
      checks++; if (Q !== 4'd0)      begin errors++; $display("FAIL load_clamp: got %0d want 0", Q); end
      drive_edge(1'b0, 1'b1, 1'b1, 4'd9);
      drive_edge(1'b1, 1'b1, 1'b1, 4'd9);
      checks++; if (tc_obs !== 1'b0) begin errors++; $display("FAIL load_tc_at9: got %b want 0", tc_obs); end
      for (int i = 0; i < 3; i++) begin
         drive_edge(1'b0, 1'b1, 1'b0, '0);
         checks++; if (Q !== 4'd9)    begin errors++; $display("FAIL hold_q[%0d]: got %0d want 9", i, Q); end
         checks++; if (Wrap !== 1'b0) begin errors++; $display("FAIL hold_wrap[%0d]: got %b want 0", i, Wrap); end
      end
   endtask

   task automatic test_direction_flip();
      logic dir [4] = '{1'b1, 1'b1, 1'b0, 1'b0};
      drive_edge(1'b0, 1'b0, 1'b1, 4'd5);
      for (int i = 0; i < 4; i++) begin
         drive_edge(1'b1, dir[i], 1'b0, '0);
         checks++; if (Q !== 4'(m_q))       begin errors++; $display("FAIL flip_q[%0d]: got %0d want %0d", i, Q, m_q); end
         checks++; if (Q_prim !== ~4'(m_q)) begin errors++; $display("FAIL flip_qp[%0d]: got %h want %h", i, Q_prim, ~4'(m_q)); end
      end
   endtask

   task automatic test_saturate_limit();
      drive_edge(1'b0, 1'b1, 1'b1, 4'd8);
      for (int i = 0; i < 3; i++) begin
         drive_edge(1'b1, 1'b1, 1'b0, '0);
         checks++; if (Q !== 4'(m_q))   begin errors++; $display("FAIL lim_q[%0d]: got %0d want %0d", i, Q, m_q); end
         checks++; if (Wrap !== m_wrap) begin errors++; $display("FAIL lim_wrap[%0d]: got %b want %b", i, Wrap, m_wrap); end
         checks++; if (tc_obs !== tc_exp) begin errors++; $display("FAIL lim_tc[%0d]: got %b want %b", i, tc_obs, tc_exp); end
      end
   endtask

   task automatic test_random();
      for (int i = 0; i < 400; i++) begin
         if ($urandom_range(49) == 0) begin
            Clear = 1'b1;
            #1;
            checks++; if (Q !== 4'd0 || Wrap !== 1'b0) begin
               errors++; $display("FAIL rnd_clear[%0d]: got q=%0d wrap=%b want 0/0", i, Q, Wrap);
            end
            Clear = 1'b0;
            m_q = 0; m_wrap = 1'b0;
         end
         drive_edge(($urandom_range(3) != 0), 1'($urandom_range(1)),
                    ($urandom_range(7) == 0), 4'($urandom_range(15)));
         checks++; if (tc_obs !== tc_exp)   begin errors++; $display("FAIL rnd_tc[%0d]: got %b want %b", i, tc_obs, tc_exp); end
         checks++; if (Q !== 4'(m_q))       begin errors++; $display("FAIL rnd_q[%0d]: got %0d want %0d", i, Q, m_q); end
         checks++; if (Q_prim !== ~4'(m_q)) begin errors++; $display("FAIL rnd_qp[%0d]: got %h want %h", i, Q_prim, ~4'(m_q)); end
         checks++; if (Wrap !== m_wrap)     begin errors++; $display("FAIL rnd_wrap[%0d]: got %b want %b", i, Wrap, m_wrap); end
      end
   endtask

   initial begin
      test_reset();
      test_up_count();
      test_down_count();
      test_load();
      test_direction_flip();
      test_saturate_limit();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
